// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the icache/dcache to burst-memory arbiter.
package mem_arb_pkg;
    localparam int LINE_W = 256;
    localparam int BEAT_W = 64;
    localparam int BEATS  = LINE_W / BEAT_W;
    localparam int ADDR_W = 32;
    localparam int CNT_W  = $clog2(BEATS);
    localparam int LSB_W  = $clog2(LINE_W);

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} arb_state_t;
    typedef enum logic {ICACHE, DCACHE} arb_src_t;

    typedef logic [LINE_W-1:0] line_t;
    typedef logic [BEAT_W-1:0] beat_t;
    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [CNT_W-1:0]  cnt_t;

    function automatic addr_t line_align(input addr_t a);
        return a & ~addr_t'(LINE_W / 8 - 1);
    endfunction
endpackage

// File: rtl/cache_mem_arbiter_if.sv
// Bundle of both cache line-miss ports and the burst memory port.
// slave: arbiter side; master: caches plus memory (environment) side.
interface cache_mem_arbiter_if;
    import mem_arb_pkg::*;

    logic  icache_pmem_read;
    addr_t icache_pmem_address;
    line_t icache_pmem_rdata;
    logic  icache_pmem_resp;

    logic  dcache_pmem_read;
    logic  dcache_pmem_write;
    addr_t dcache_pmem_address;
    line_t dcache_pmem_wdata;
    line_t dcache_pmem_rdata;
    logic  dcache_pmem_resp;

    logic  mem_read;
    logic  mem_write;
    addr_t mem_addr;
    beat_t mem_wdata;
    beat_t mem_rdata;
    logic  mem_resp;

    modport slave (
        input  icache_pmem_read, icache_pmem_address,
        output icache_pmem_rdata, icache_pmem_resp,
        input  dcache_pmem_read, dcache_pmem_write, dcache_pmem_address, dcache_pmem_wdata,
        output dcache_pmem_rdata, dcache_pmem_resp,
        output mem_read, mem_write, mem_addr, mem_wdata,
        input  mem_rdata, mem_resp
    );

    modport master (
        output icache_pmem_read, icache_pmem_address,
        input  icache_pmem_rdata, icache_pmem_resp,
        output dcache_pmem_read, dcache_pmem_write, dcache_pmem_address, dcache_pmem_wdata,
        input  dcache_pmem_rdata, dcache_pmem_resp,
        input  mem_read, mem_write, mem_addr, mem_wdata,
        output mem_rdata, mem_resp
    );
endinterface

// File: rtl/line_burst_adaptor.sv
// Beat counter, line buffer and beat slice mux: splits/assembles a cacheline
// over BEATS memory beats; counter and buffer hold through beat gaps.
module line_burst_adaptor
    import mem_arb_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  i_start,
    input  line_t i_load_line,
    input  logic  i_beat,
    input  logic  i_capture,
    input  beat_t i_rdata,
    output logic  o_last,
    output beat_t o_wdata,
    output line_t o_line
);
    cnt_t              r_cnt;
    line_t             r_line;
    logic [LSB_W-1:0]  w_lsb;

    assign w_lsb = LSB_W'(r_cnt) * LSB_W'(BEAT_W);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt  <= '0;
            r_line <= '0;
        end else if (i_start) begin
            r_cnt  <= '0;
            r_line <= i_load_line;
        end else if (i_beat) begin
            r_cnt <= r_cnt + 1'b1;
            if (i_capture) begin
                r_line[w_lsb +: BEAT_W] <= i_rdata;
            end
        end
    end

    assign o_last  = i_beat && (r_cnt == cnt_t'(BEATS - 1));
    assign o_wdata = r_line[w_lsb +: BEAT_W];
    assign o_line  = r_line;
endmodule

// File: rtl/cache_mem_arbiter.sv
// Grants one cache line transfer at a time onto the 4-beat burst memory port.
// Fixed dcache priority; define ARB_ROUND_ROBIN_EN to alternate on contention.
module cache_mem_arbiter
    import mem_arb_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    cache_mem_arbiter_if.slave bus
);
    arb_state_t r_state, w_state_nxt;
    arb_src_t   r_src, w_grant_src;
    addr_t      r_addr;
    logic       w_ireq, w_dreq, w_grant, w_grant_wr, w_beat, w_last;
    beat_t      w_wdata;
    line_t      w_line;

    assign w_ireq     = bus.icache_pmem_read;
    assign w_dreq     = bus.dcache_pmem_read | bus.dcache_pmem_write;
    assign w_grant    = (r_state == IDLE) && (w_ireq || w_dreq);
    // an illegal read+write from the dcache is serviced as a write
    assign w_grant_wr = (w_grant_src == DCACHE) && bus.dcache_pmem_write;
    assign w_beat     = bus.mem_resp && ((r_state == READ) || (r_state == WRITE));

`ifdef ARB_ROUND_ROBIN_EN
    arb_src_t r_last_src;

    always_comb begin
        w_grant_src = w_dreq ? DCACHE : ICACHE;
        if (w_ireq && w_dreq) begin
            w_grant_src = (r_last_src == ICACHE) ? DCACHE : ICACHE;
        end
    end

    // only contended grants move the pointer
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_src <= ICACHE;
        end else if (w_grant && w_ireq && w_dreq) begin
            r_last_src <= w_grant_src;
        end
    end
`else
    assign w_grant_src = w_dreq ? DCACHE : ICACHE;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_src   <= ICACHE;
            r_addr  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_grant) begin
                r_src  <= w_grant_src;
                r_addr <= line_align((w_grant_src == DCACHE) ? bus.dcache_pmem_address
                                                             : bus.icache_pmem_address);
            end
        end
    end

    always_comb begin
        w_state_nxt           = r_state;
        bus.mem_read          = 1'b0;
        bus.mem_write         = 1'b0;
        bus.mem_addr          = r_addr;
        bus.mem_wdata         = '0;
        bus.icache_pmem_resp  = 1'b0;
        bus.icache_pmem_rdata = '0;
        bus.dcache_pmem_resp  = 1'b0;
        bus.dcache_pmem_rdata = '0;
        unique case (r_state)
            IDLE: begin
                if (w_grant) begin
                    w_state_nxt = w_grant_wr ? WRITE : READ;
                end
            end
            READ: begin
                bus.mem_read = 1'b1;
                if (w_last) begin
                    w_state_nxt = DONE;
                end
            end
            WRITE: begin
                bus.mem_write = 1'b1;
                bus.mem_wdata = w_wdata;
                if (w_last) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
                if (r_src == ICACHE) begin
                    bus.icache_pmem_resp  = 1'b1;
                    bus.icache_pmem_rdata = w_line;
                end else begin
                    bus.dcache_pmem_resp  = 1'b1;
                    bus.dcache_pmem_rdata = w_line;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    line_burst_adaptor u_adaptor (
        .clk         (clk),
        .rst         (rst),
        .i_start     (w_grant),
        .i_load_line (w_grant_wr ? bus.dcache_pmem_wdata : '0),
        .i_beat      (w_beat),
        .i_capture   (r_state == READ),
        .i_rdata     (bus.mem_rdata),
        .o_last      (w_last),
        .o_wdata     (w_wdata),
        .o_line      (w_line)
    );

    a_dcache_rw_exclusive: assert property (@(posedge clk) disable iff (rst)
        !(bus.dcache_pmem_read && bus.dcache_pmem_write));
endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Randomized bench: both caches and a burst memory model around the arbiter.
module tb_cache_mem_arbiter;
    import mem_arb_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cache_mem_arbiter_if bus();
    cache_mem_arbiter dut (.clk(clk), .rst(rst), .bus(bus));

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [LINE_W-1:0] got, input logic [LINE_W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Backing store: lines never written hold an address-derived pattern.
    line_t mem_model [addr_t];
    function automatic line_t model_get(input addr_t a);
        if (mem_model.exists(a)) return mem_model[a];
        return {a ^ 32'h0bad_f00d, ~a, a + 32'd7, a * 3, {16'hc0de, a[15:0]},
                a ^ 32'h5555_aaaa, 32'h1234_0000 | {16'h0, a[15:0]}, a};
    endfunction

    typedef struct { addr_t addr; bit wr; } burst_t;
    burst_t burst_log [$];

    int    resp_mode = 0;   // 0: every cycle, 1: random, 2: from resp_pat
    bit    noise_en  = 0;
    bit    resp_pat [$];
    int    nbeat     = 0;
    int    last_beat_cyc = -1;
    addr_t burst_addr = '0;
    line_t wline;

    initial begin : mem_responder
        bit r, act, fin, rst_edge, act_q, wr_q;
        beat_t wbeat_q;
        line_t rl;
        act_q = 0; wr_q = 0; wbeat_q = '0;
        bus.mem_resp = 1'b0;
        bus.mem_rdata = '0;
        forever begin
            @(posedge clk);
            fin = 0;
            rst_edge = rst;
            if (rst) begin
                nbeat = 0;
            end else if (act_q && bus.mem_resp) begin
                if (wr_q) wline[nbeat*BEAT_W +: BEAT_W] = wbeat_q;
                nbeat++;
                if (nbeat == BEATS) begin
                    fin = 1;
                    if (wr_q) mem_model[burst_addr] = wline;
                    burst_log.push_back('{addr: burst_addr, wr: wr_q});
                end
            end
            #1;
            act = bus.mem_read | bus.mem_write;
            if (fin) begin
                last_beat_cyc = cyc;
                check_eq("mem_req_drop", act, 0);
            end else if (act_q && !rst_edge) begin
                check_eq("mem_req_held", act, 1);
            end
            if (act && !act_q) begin
                burst_addr = bus.mem_addr;
                nbeat = 0;
                wline = '0;
                check_eq("addr_aligned", bus.mem_addr[4:0], 0);
            end else if (act) begin
                check_eq("mem_addr_hold", bus.mem_addr, burst_addr);
                check_eq("mem_dir_hold", bus.mem_write, wr_q);
            end
            if (!act) nbeat = 0;
            if (act && nbeat < BEATS) begin
                if (resp_mode == 0) r = 1'b1;
                else if (resp_mode == 1) r = 1'($urandom_range(0, 1));
                else r = (resp_pat.size() > 0) ? resp_pat.pop_front() : 1'b1;
            end else begin
                r = noise_en ? 1'($urandom_range(0, 1)) : 1'b0;
            end
            rl = model_get(burst_addr);
            bus.mem_resp  = r;
            bus.mem_rdata = (act && bus.mem_read && nbeat < BEATS) ? rl[nbeat*BEAT_W +: BEAT_W]
                                                                  : {$urandom, $urandom};
            act_q   = act;
            wr_q    = bus.mem_write;
            wbeat_q = bus.mem_wdata;
        end
    end

    int iresp_cnt = 0;
    int dresp_cnt = 0;
    always @(negedge clk) begin
        if (bus.icache_pmem_resp === 1'b1) begin
            iresp_cnt++;
            check_eq("iresp_has_req", bus.icache_pmem_read, 1);
        end
        if (bus.dcache_pmem_resp === 1'b1) begin
            dresp_cnt++;
            check_eq("dresp_has_req", bus.dcache_pmem_read | bus.dcache_pmem_write, 1);
        end
    end

    task automatic cache_xfer(input bit is_d, input bit wr, input addr_t addr, input line_t wdata, output int lat);
        line_t got;
        bit    seen;
        addr_t a;
        a = line_align(addr);
        seen = 0;
        @(posedge clk); #1;
        if (is_d) begin
            bus.dcache_pmem_address = addr;
            bus.dcache_pmem_wdata   = wdata;
            bus.dcache_pmem_write   = wr;
            bus.dcache_pmem_read    = !wr;
        end else begin
            bus.icache_pmem_address = addr;
            bus.icache_pmem_read    = 1'b1;
        end
        lat = 0;
        got = '0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge clk);
            lat++;
            seen = is_d ? bus.dcache_pmem_resp : bus.icache_pmem_resp;
        end
        check_eq(is_d ? "dresp_seen" : "iresp_seen", seen, 1);
        if (seen && burst_log.size() > 0) begin
            got = is_d ? bus.dcache_pmem_rdata : bus.icache_pmem_rdata;
            check_eq("resp_after_last_beat", cyc, last_beat_cyc);
            check_eq("burst_addr", burst_log[$].addr, a);
            check_eq("burst_dir", burst_log[$].wr, wr);
            if (wr) check_eq("wr_line", model_get(a), wdata);
            else    check_eq(is_d ? "d_rd_line" : "i_rd_line", got, model_get(a));
        end
        @(posedge clk); #1;
        if (is_d) begin
            bus.dcache_pmem_read  = 1'b0;
            bus.dcache_pmem_write = 1'b0;
        end else begin
            bus.icache_pmem_read  = 1'b0;
        end
        @(negedge clk);
        check_eq("resp_one_cycle", is_d ? bus.dcache_pmem_resp : bus.icache_pmem_resp, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : main
        line_t wl;
        int    lat_i, lat_d, n0, ic0, di, dd;
        bit    dwr;
        addr_t ia, da;
        addr_t exp_first [2];
        addr_t exp_second [2];

        rst = 1'b1;
        bus.icache_pmem_read = 1'b0; bus.icache_pmem_address = '0;
        bus.dcache_pmem_read = 1'b0; bus.dcache_pmem_write = 1'b0;
        bus.dcache_pmem_address = '0; bus.dcache_pmem_wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_mem_read", bus.mem_read, 0);
        check_eq("rst_mem_write", bus.mem_write, 0);
        check_eq("rst_iresp", bus.icache_pmem_resp, 0);
        check_eq("rst_dresp", bus.dcache_pmem_resp, 0);
        check_eq("rst_mem_addr", bus.mem_addr, 0);
        check_eq("rst_mem_wdata", bus.mem_wdata, 0);
        check_eq("rst_irdata", bus.icache_pmem_rdata, 0);
        check_eq("rst_drdata", bus.dcache_pmem_rdata, 0);
        @(posedge clk); #1 rst = 1'b0;

        // lone icache read, back-to-back beats
        mem_model[32'h0000_0060] = {{8{8'h44}}, {8{8'h33}}, {8{8'h22}}, {8{8'h11}}};
        cache_xfer(0, 0, 32'h0000_0064, '0, lat_i);
        check_eq("icache_min_latency", lat_i, 6);
        check_eq("no_dresp_on_iread", dresp_cnt, 0);

        // dcache writeback, beat k = {8{A0+k}}
        for (int k = 0; k < BEATS; k++) wl[k*BEAT_W +: BEAT_W] = {8{8'hA0 + 8'(k)}};
        cache_xfer(1, 1, 32'h0000_1000, wl, lat_d);
        check_eq("dcache_min_latency", lat_d, 6);

        // contention, twice
`ifdef ARB_ROUND_ROBIN_EN
        exp_first  = '{32'h0002_0000, 32'h0000_0200};
        exp_second = '{32'h0000_0200, 32'h0002_0000};
`else
        exp_first  = '{32'h0002_0000, 32'h0002_0000};
        exp_second = '{32'h0000_0200, 32'h0000_0200};
`endif
        resp_mode = 1;
        for (int r = 0; r < 2; r++) begin
            n0 = burst_log.size();
            fork
                cache_xfer(0, 0, 32'h0000_0200, '0, lat_i);
                cache_xfer(1, 0, 32'h0002_0000, '0, lat_d);
            join
            check_eq("contend_first", burst_log[n0].addr, exp_first[r]);
            check_eq("contend_second", burst_log[n0+1].addr, exp_second[r]);
        end

        // gapped beats 1,0,0,1,1,0,1
        resp_mode = 2;
        resp_pat = '{1, 0, 0, 1, 1, 0, 1};
        cache_xfer(0, 0, 32'h0000_0300, '0, lat_i);
        check_eq("gap_pattern_used", resp_pat.size(), 0);
        check_eq("gap_latency", lat_i, 9);

        // reset after beat 2 of an icache read
        resp_mode = 0;
        @(posedge clk); #1;
        bus.icache_pmem_address = 32'h0000_0480;
        bus.icache_pmem_read = 1'b1;
        for (int i = 0; i < 50 && nbeat < 2; i++) @(negedge clk);
        check_eq("rst_wait_beats", nbeat, 2);
        ic0 = iresp_cnt;
        rst = 1'b1;
        bus.icache_pmem_read = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check_eq("midrst_mem_read", bus.mem_read, 0);
        check_eq("midrst_mem_write", bus.mem_write, 0);
        repeat (8) @(negedge clk);
        check_eq("midrst_no_resp", iresp_cnt, ic0);
        cache_xfer(1, 0, 32'h0003_0040, '0, lat_d);

        // dcache request raised mid icache burst
        resp_mode = 1;
        n0 = burst_log.size();
        for (int k = 0; k < BEATS; k++) wl[k*BEAT_W +: BEAT_W] = {$urandom, $urandom};
        fork
            cache_xfer(0, 0, 32'h0000_0a00, '0, lat_i);
            begin
                for (int i = 0; i < 100 && nbeat < 1; i++) @(negedge clk);
                cache_xfer(1, 1, 32'h0004_0020, wl, lat_d);
            end
        join
        check_eq("midburst_first", burst_log[n0].addr, 32'h0000_0a00);
        check_eq("midburst_second", burst_log[n0+1].addr, 32'h0004_0020);

        // random traffic with ignored mem_resp noise outside bursts
        noise_en = 1;
        for (int it = 0; it < 40; it++) begin
            ia  = {20'h0, 12'($urandom)};
            da  = 32'h0001_0000 | {16'h0, 16'($urandom)};
            dwr = 1'($urandom_range(0, 1));
            for (int k = 0; k < BEATS; k++) wl[k*BEAT_W +: BEAT_W] = {$urandom, $urandom};
            di = $urandom_range(0, 3);
            dd = $urandom_range(0, 3);
            fork
                begin repeat (di) @(posedge clk); cache_xfer(0, 0, ia, '0, lat_i); end
                begin repeat (dd) @(posedge clk); cache_xfer(1, dwr, da, wl, lat_d); end
            join
        end
        noise_en = 0;
        repeat (4) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
